// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display path.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd_i  4-bit BCD code; 10..15 are invalid and show a dash
//   seg_o  active-low segments, bit 0 = a ... bit 6 = g
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp7seg_scan.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Digits/Dp are captured once per frame so a frame never mixes old and new values.
// Ports:
//   Clk, Rst  clock and synchronous active-high reset
//   Digits    four BCD digits, [3:0] = rightmost digit
//   Dp        decimal point request per digit, active-high
//   Blank_lz  leading-zero blanking enable, sampled live
//   An        anode enables, active-low, one-cold on the scanned digit
//   Seg       segment cathodes, active-low
//   Dp_n      decimal point cathode, active-low
//   Frame     one-cycle pulse on the capture edge
module disp7seg_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIV = 100000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Digits,
  input  logic [3:0]  Dp,
  input  logic        Blank_lz,
  output logic [3:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp_n,
  output logic        Frame
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_digits_q, snap_digits_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;

  logic          tick;
  logic          frame;
  logic [3:0]    cur_bcd;
  logic [6:0]    cur_seg;
  logic [3:0]    zero_from;  // zero_from[i]: snapshot digits i..3 are all zero
  logic          blank;

  assign tick  = (presc_q == PRESC_MAX);
  assign frame = tick && (idx_q == 2'd3);
  assign Frame = frame;

  assign cur_bcd = snap_digits_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

  always_comb begin
    zero_from    = '0;
    zero_from[3] = (snap_digits_q[15:12] == 4'h0);
    zero_from[2] = zero_from[3] && (snap_digits_q[11:8] == 4'h0);
    zero_from[1] = zero_from[2] && (snap_digits_q[7:4] == 4'h0);
    zero_from[0] = 1'b0;  // rightmost digit always shows
    blank        = Blank_lz && zero_from[idx_q];
  end

  always_comb begin
    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    snap_digits_d = frame ? Digits : snap_digits_q;
    snap_dp_d     = frame ? Dp : snap_dp_q;
    an_d          = 4'hF;
    seg_d         = SEG_OFF;
    dp_n_d        = 1'b1;
    if (!blank) begin
      an_d   = ~(4'b0001 << idx_q);
      seg_d  = cur_seg;
      dp_n_d = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc_q       <= '0;
      idx_q         <= 2'd0;
      snap_digits_q <= 16'h0000;
      snap_dp_q     <= 4'h0;
      an_q          <= 4'hF;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
    end
  end

  assign An   = an_q;
  assign Seg  = seg_q;
  assign Dp_n = dp_n_q;

endmodule

// File: tb/tb_disp7seg_scan.sv
// Bench for disp7seg_scan with DIV=4: directed scenarios with literal expectations,
// then random stimulus, all checked every cycle against a cycle-count based model.
module tb_disp7seg_scan;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 4 * DIV;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Digits;
  logic [3:0]  Dp;
  logic        Blank_lz;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Dp_n;
  logic        Frame;

  int checks   = 0;
  int failures = 0;

  disp7seg_scan #(.DIV(DIV)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Digits   (Digits),
    .Dp       (Dp),
    .Blank_lz (Blank_lz),
    .An       (An),
    .Seg      (Seg),
    .Dp_n     (Dp_n),
    .Frame    (Frame)
  );

  always #5 Clk = ~Clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model: m_c counts cycles since the last reset edge; everything derives from it.
  int          m_c     = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_snap  = 16'h0;
  logic [3:0]  m_dp    = 4'h0;
  logic [3:0]  e_an    = 4'hF;
  logic [6:0]  e_seg   = 7'h7F;
  logic        e_dpn   = 1'b1;
  logic        e_frame = 1'b0;

  always @(posedge Clk) begin
    int  idx;
    bit  blk;
    if (Rst) begin
      m_c = 0; m_snap = 16'h0; m_dp = 4'h0; m_valid = 1'b1;
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
    end else begin
      idx = (m_c / DIV) % 4;
      blk = Blank_lz && (idx > 0) && ((m_snap >> (idx * 4)) == 16'h0);
      if (blk) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
      end else begin
        e_an  = 4'hF ^ (4'b0001 << idx);
        e_seg = seg_tab[m_snap[idx*4 +: 4]];
        e_dpn = ~m_dp[idx];
      end
      if (m_c % FRAME == FRAME - 1) begin
        m_snap = Digits;
        m_dp   = Dp;
      end
      m_c++;
    end
    e_frame = (m_c % FRAME == FRAME - 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("cycle", {Frame, Dp_n, Seg, An}, {e_frame, e_dpn, e_seg, e_an});
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic goto(input int n);
    int budget = 1000;
    while (m_c != n && budget > 0) begin
      step();
      budget--;
    end
    if (m_c != n) chk("goto_timeout", m_c, n);
  endtask

  initial begin
    Rst = 1'b1; Digits = 16'h0; Dp = 4'h0; Blank_lz = 1'b0;
    repeat (3) step();
    chk("rst_an", An, 4'hF);
    chk("rst_seg", Seg, 7'h7F);
    chk("rst_frame", Frame, 1'b0);
    Rst = 1'b0;
    chk("rel0_an", An, 4'hF);
    chk("rel0_dpn", Dp_n, 1'b1);
    goto(1);
    chk("rel1_an", An, 4'b1110);
    chk("rel1_seg", Seg, 7'h40);
    Digits = 16'h1234;
    goto(5);  chk("zero_d1_an", An, 4'b1101);
    goto(13); chk("zero_d3_an", An, 4'b0111);
    chk("zero_d3_seg", Seg, 7'h40);
    goto(15); chk("frame15", Frame, 1'b1);
    goto(16); chk("frame16", Frame, 1'b0);
    goto(17); chk("n1234_d0", Seg, 7'h19);
    goto(21); chk("n1234_d1", Seg, 7'h30);
    goto(25); chk("n1234_d2", Seg, 7'h24);
    goto(29); chk("n1234_d3", Seg, 7'h79);
    chk("n1234_d3_an", An, 4'b0111);
    goto(31); chk("frame31", Frame, 1'b1);
    // leading-zero blanking
    goto(33); Blank_lz = 1'b1; Digits = 16'h0050;
    goto(49); chk("lz_d0", {An, Seg}, {4'b1110, 7'h40});
    Digits = 16'h0000;
    goto(53); chk("lz_d1", {An, Seg}, {4'b1101, 7'h12});
    goto(57); chk("lz_d2", {An, Seg}, {4'b1111, 7'h7F});
    goto(61); chk("lz_d3", An, 4'b1111);
    goto(65); chk("lz0_d0", {An, Seg}, {4'b1110, 7'h40});
    Digits = 16'h00A0; Dp = 4'b0010;
    goto(69); chk("lz0_d1", An, 4'b1111);
    goto(81); chk("inv_d0", {An, Seg, Dp_n}, {4'b1110, 7'h40, 1'b1});
    goto(85); chk("inv_d1", {An, Seg, Dp_n}, {4'b1101, 7'h3F, 1'b0});
    // tear-free capture
    Digits = 16'h1111; Dp = 4'h0;
    goto(105); Digits = 16'h9999;
    chk("tear_d2", Seg, 7'h79);
    goto(109); chk("tear_d3", Seg, 7'h79);
    goto(113); chk("new_d0", Seg, 7'h10);
    // reset during digit 2 slot
    goto(122);
    Rst = 1'b1;
    step();
    chk("mid_rst_an", An, 4'hF);
    chk("mid_rst_frame", Frame, 1'b0);
    Rst = 1'b0;
    step();
    chk("after_rst", {An, Seg}, {4'b1110, 7'h40});
    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) Digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) Dp = 4'($urandom);
      if ($urandom_range(0, 31) == 0) Blank_lz = ~Blank_lz;
      if ($urandom_range(0, 2) == 0) Digits[15:8] = 8'h00;
      Rst = ($urandom_range(0, 299) == 0);
      step();
    end
    Rst = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
